// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
//
// Round-robin arbiter sharing one WIDTH-bit storage register among NREQ
// requesters. A request seen in IDLE is granted for exactly one cycle
// (GRANT); if the granted requester still holds its request at the closing
// edge, its data slice is committed into the shared register.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  width of the shared register and of each data slice
//   IDXW   owner index width, ceil(log2(NREQ))
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request per requester, bit i = requester i
//   wr_data   requester i data on [i*WIDTH +: WIDTH]
//   clr       synchronous clear of q_valid (loses to a commit)
//   gnt       registered one-hot grant
//   q         shared register contents
//   q_owner   index of the requester that last wrote q
//   q_valid   q written since reset or last clr
//   busy      high while in GRANT
//   wr_count  committed write count, wraps at 16 bits
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDXW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   input  logic                  clr,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic [IDXW-1:0]       q_owner,
   output logic                  q_valid,
   output logic                  busy,
   output logic [15:0]           wr_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

   state_t            state;
   logic [IDXW-1:0]   ptr;
   logic [IDXW-1:0]   g_idx;

   logic              sel_found;
   logic [IDXW-1:0]   sel_idx;
   logic [IDXW-1:0]   cand_idx;
   int unsigned       cand;
   logic [WIDTH-1:0]  g_data;
   logic              g_req;

   // Search from ptr upward, wrapping at NREQ; first set request wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDXW'(cand);
         if (!sel_found && req[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // Data and request of the requester currently holding the grant.
   always_comb begin
      g_data = wr_data[g_idx*WIDTH +: WIDTH];
      g_req  = req[g_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         g_idx    <= '0;
         gnt      <= '0;
         q        <= '0;
         q_owner  <= '0;
         q_valid  <= 1'b0;
         busy     <= 1'b0;
         wr_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  q_valid <= 1'b0;
               end
               if (sel_found) begin
                  g_idx <= sel_idx;
                  gnt   <= GNT_ONE << sel_idx;
                  busy  <= 1'b1;
                  state <= GRANT;
               end else begin
                  gnt  <= '0;
                  busy <= 1'b0;
               end
            end
            GRANT: begin
               if (g_req) begin
                  // Commit: takes priority over a coincident clr.
                  q        <= g_data;
                  q_owner  <= g_idx;
                  q_valid  <= 1'b1;
                  wr_count <= wr_count + 16'd1;
                  ptr      <= (g_idx == LAST_IDX) ? '0 : g_idx + IDXW'(1);
               end else if (clr) begin
                  q_valid <= 1'b0;
               end
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Self-checking bench: directed scenarios followed by random traffic, all
// compared every cycle against an integer-level behavioural model.
// ---------------------------------------------------------------------------
module tb_dff_bank_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDXW  = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] wr_data = '0;
   logic                  clr = 1'b0;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic [IDXW-1:0]       q_owner;
   logic                  q_valid;
   logic                  busy;
   logic [15:0]           wr_count;

   dff_bank_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .wr_data  (wr_data),
      .clr      (clr),
      .gnt      (gnt),
      .q        (q),
      .q_owner  (q_owner),
      .q_valid  (q_valid),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: pending grant index (-1 = none), pointer, outputs.
   int               m_ptr;
   int               m_pend;
   logic [WIDTH-1:0] m_q;
   int               m_owner;
   logic             m_valid;
   logic [15:0]      m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_pend  = -1;
      m_q     = '0;
      m_owner = 0;
      m_valid = 1'b0;
      m_cnt   = '0;
   endtask

   task automatic model_step();
      if (m_pend < 0) begin
         if (clr) m_valid = 1'b0;
         for (int k = 0; k < int'(NREQ); k++) begin
            int c;
            c = (m_ptr + k) % int'(NREQ);
            if (m_pend < 0 && req[c]) m_pend = c;
         end
      end else begin
         if (req[m_pend]) begin
            m_q     = wr_data[m_pend*int'(WIDTH) +: WIDTH];
            m_owner = m_pend;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
            m_ptr   = (m_pend + 1) % int'(NREQ);
         end else if (clr) begin
            m_valid = 1'b0;
         end
         m_pend = -1;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [31:0] exp_gnt;
      exp_gnt = (m_pend < 0) ? 32'd0 : (32'd1 << m_pend);
      check({tag, ".gnt"},      32'(gnt),      exp_gnt);
      check({tag, ".busy"},     32'(busy),     (m_pend < 0) ? 32'd0 : 32'd1);
      check({tag, ".q"},        32'(q),        32'(m_q));
      check({tag, ".q_owner"},  32'(q_owner),  32'(m_owner));
      check({tag, ".q_valid"},  32'(q_valid),  32'(m_valid));
      check({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
   endtask

   task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d,
                        input logic c, input string tag);
      @(negedge clk);
      req     = r;
      wr_data = d;
      clr     = c;
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [NREQ*WIDTH-1:0] d;

   initial begin
      model_reset();

      // Reset asserted mid-cycle, then idle.
      #12 rst_n = 1'b0;
      #1 compare_all("reset0");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cycle('0, 32'(i * 7), 1'b0, "idle");

      // Single request from requester 2.
      d = {8'h77, 8'hA5, 8'h66, 8'h55};
      cycle(4'b0100, d, 1'b0, "single_g");
      check("single_gnt", 32'(gnt), 32'h4);
      cycle(4'b0100, d, 1'b0, "single_c");
      check("single_q", 32'(q), 32'hA5);
      check("single_owner", 32'(q_owner), 32'd2);
      check("single_cnt", 32'(wr_count), 32'd1);
      cycle(4'b0000, d, 1'b0, "single_i");
      check("single_gnt_drop", 32'(gnt), 32'h0);

      // Rotation with all requests held.
      do_reset();
      d = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 10; i++) begin
         cycle(4'b1111, d, 1'b0, "rot");
         if (i % 2 == 0) check("rot_gnt", 32'(gnt), 32'd1 << ((i / 2) % 4));
         else            check("rot_q", 32'(q), 32'h10 + 32'((i / 2) % 4));
      end
      check("rot_cnt", 32'(wr_count), 32'd5);

      // Abort: requester 1 drops during GRANT; pointer must not advance.
      cycle(4'b0010, d, 1'b0, "abort_g");
      cycle(4'b0000, d, 1'b0, "abort_x");
      check("abort_cnt", 32'(wr_count), 32'd5);
      check("abort_q", 32'(q), 32'h10);
      cycle(4'b0011, d, 1'b0, "abort_rg");
      check("abort_regrant", 32'(gnt), 32'h2);
      cycle(4'b0011, d, 1'b0, "abort_rc");
      cycle(4'b0000, d, 1'b0, "abort_i");

      // clr in IDLE, then clr coinciding with a commit.
      cycle(4'b0000, d, 1'b1, "clr_idle");
      check("clr_valid", 32'(q_valid), 32'd0);
      check("clr_q_kept", 32'(q), 32'h11);
      d = {8'h00, 8'h00, 8'h00, 8'h3C};
      cycle(4'b0001, d, 1'b0, "clr_g");
      cycle(4'b0001, d, 1'b1, "clr_c");
      check("clr_commit_valid", 32'(q_valid), 32'd1);
      check("clr_commit_q", 32'(q), 32'h3C);
      cycle(4'b0000, d, 1'b0, "clr_i");

      // Asynchronous reset in the middle of a GRANT cycle.
      cycle(4'b1000, {8'hEE, 24'h0}, 1'b0, "ar_g");
      check("ar_gnt_pre", 32'(gnt), 32'h8);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("ar");
      check("ar_gnt", 32'(gnt), 32'h0);
      check("ar_q", 32'(q), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b0000, d, 1'b0, "ar_i");

      // wr_count wrap: preload the counter then commit once.
      @(negedge clk);
      force dut.wr_count = 16'hFFFF;
      #1 release dut.wr_count;
      m_cnt = 16'hFFFF;
      check("wrap_preload", 32'(wr_count), 32'hFFFF);
      d = {8'h44, 8'h5A, 8'h22, 8'h11};
      cycle(4'b0100, d, 1'b0, "wrap_g");
      cycle(4'b0100, d, 1'b0, "wrap_c");
      check("wrap_cnt", 32'(wr_count), 32'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [NREQ-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
         cycle(r, NREQ*WIDTH'($urandom), ($urandom_range(0, 7) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops) among NREQ requesters.
- Each requester raises a request and holds its data. The arbiter grants one requester at a time, then loads that requester's data into the shared register.
- Sits between the requesters and the shared flip-flop bank. It is the only writer of that bank.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, width of the shared register and of each requester's data.
- IDXW, 2, width of the owner index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  request per requester; bit i belongs to requester i.
- wr_data  input  NREQ*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of q_valid.
- gnt  output  NREQ  one-hot grant, registered.
- q  output  WIDTH  contents of the shared register.
- q_owner  output  IDXW  index of the requester that last wrote q.
- q_valid  output  1  q holds data written since reset or the last clr.
- busy  output  1  high while the FSM is in GRANT.
- wr_count  output  16  count of committed writes; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n low, async):
  - gnt=0, q=0, q_owner=0, q_valid=0, busy=0, wr_count=0.
  - Round-robin pointer ptr=0; FSM state = IDLE.
  - Reset takes effect immediately, including mid-GRANT. Any grant in progress is dropped without a write.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req != 0 at a clock edge: select the first requester with req set, searching from index ptr upward modulo NREQ.
  - gnt becomes one-hot for that index; FSM goes to GRANT; busy=1.
  - If req == 0: stay in IDLE with gnt=0.
- GRANT (always lasts exactly one cycle):
  - If req[g] is still 1 at the closing edge (commit):
    - q <= wr_data slice g; q_owner <= g; q_valid <= 1.
    - wr_count increments by 1.
    - ptr <= (g+1) mod NREQ.
  - If req[g] is 0 at the closing edge (abort): no change to q, q_owner, q_valid, wr_count or ptr.
  - In both cases gnt <= 0, busy <= 0, FSM goes to IDLE.
  - Requests arriving during GRANT are not evaluated until IDLE.
- Requester handshake:
  - Hold req[i] and data stable until the clock edge at which gnt[i]=1 is sampled.
  - Deassert req[i] or change data after that edge.
  - A requester that keeps req high is re-eligible, but at lowest priority because ptr has moved past it.
- Latency and throughput:
  - A request arriving in IDLE sees gnt one cycle after req is sampled.
  - q updates at the edge that ends GRANT, two edges after req is sampled.
  - Maximum throughput is one write per two cycles.
- clr:
  - At an edge where no commit occurs, clr=1 forces q_valid <= 0; q and q_owner are unchanged.
  - If clr and a commit coincide, the commit wins and q_valid = 1.
- Fairness: with all NREQ requests continuously high, grants rotate 0,1,...,NREQ-1,0,... Each requester waits at most NREQ grant slots.
- wr_count counts commits only; aborts do not increment it.

Test Plan:
- Reset then idle: assert rst_n low mid-cycle, release; hold req=0 for 10 cycles -> all outputs 0, gnt never nonzero.
- Single request: req=4'b0100, wr_data slice 2 = 8'hA5, drop req after gnt is sampled -> gnt=4'b0100 for exactly 1 cycle, then q=8'hA5, q_owner=2, q_valid=1, wr_count=1.
- Rotation: req=4'b1111 held, data slice i = 8'h10+i -> gnt sequence 0001,0010,0100,1000,0001 on alternate cycles; q goes 10,11,12,13,10; wr_count=5.
- Abort: req=4'b0010, drop req[1] during the GRANT cycle -> q, q_valid, wr_count unchanged; next req=4'b0011 grants index 1 again because ptr did not advance.
- clr interaction:
  - clr=1 in IDLE after a write -> q_valid=0, q retained.
  - clr=1 on a commit edge with data 8'h3C -> q_valid=1, q=8'h3C.
- Async reset mid-GRANT: pull rst_n low while gnt=4'b1000 -> gnt=0 and q=0 immediately, no write recorded. wr_count wrap: preload to 0xFFFF via 65535 commits (or force) -> next commit gives 0.
